// File: rtl/branch_predict_unit.sv
// Branch resolve + per-PC 2-bit saturating-counter predictor.
// Optional perf counters (br_count / mp_count) enabled by BRANCH_PERF_CNT_EN.
//
// state | meaning
// SNT   | strongly not-taken (00)
// WNT   | weakly not-taken (01), reset value
// WT    | weakly taken (10)
// ST    | strongly taken (11)
module branch_predict_unit #(
  parameter int         DATA_W    = 16,
  parameter int         PC_W      = 16,
  parameter int         TBL_DEPTH = 16,
  parameter int         IDX_W     = $clog2(TBL_DEPTH),
  parameter logic [3:0] OPC_BEQ   = 4'b0100,
  parameter logic [3:0] OPC_BLT   = 4'b0101,
  parameter logic [3:0] OPC_BGT   = 4'b0110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   res_pc,
  input  logic              res_pred,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd15,
  input  logic [3:0]        opcode,
  input  logic              branch,
  output logic              pcsrc,
  output logic              mispredict,
  output logic              flush
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [15:0]       br_count,
  output logic [15:0]       mp_count
`endif
);

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;

  ctr_t             tbl [TBL_DEPTH];
  ctr_t             cur_ctr;
  ctr_t             nxt_ctr;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic             taken;
  logic             train;
  logic             pcsrc_d;
  logic             mis_d;

  assign fetch_idx = fetch_pc[IDX_W-1:0];
  assign res_idx   = res_pc[IDX_W-1:0];
  assign train     = res_valid & branch;
  assign cur_ctr   = tbl[res_idx];

  always_comb begin
    taken = 1'b0;
    if (branch) begin
      case (opcode)
        OPC_BEQ: taken = (rd1 == rd15);
        OPC_BLT: taken = ($signed(rd1) < $signed(rd15));
        OPC_BGT: taken = ($signed(rd1) > $signed(rd15));
        default: taken = 1'b0;
      endcase
    end
  end

  // Counter state register: only the resolved entry moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) tbl[i] <= WNT;
    end else if (train) begin
      tbl[res_idx] <= nxt_ctr;
    end
  end

  always_comb begin
    nxt_ctr = cur_ctr;
    case (cur_ctr)
      SNT: nxt_ctr = taken ? WNT : SNT;
      WNT: nxt_ctr = taken ? WT  : SNT;
      WT:  nxt_ctr = taken ? ST  : WNT;
      ST:  nxt_ctr = taken ? ST  : WT;
      default: nxt_ctr = WNT;
    endcase
  end

  always_comb begin
    pcsrc_d = 1'b0;
    mis_d   = 1'b0;
    if (res_valid) begin
      pcsrc_d = taken;
      mis_d   = branch & (taken != res_pred);
    end
  end

  // Table read here sees the pre-update entry on a same-index collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pcsrc      <= 1'b0;
      mispredict <= 1'b0;
      flush      <= 1'b0;
    end else begin
      pred_valid <= fetch_valid;
      if (fetch_valid) pred_taken <= tbl[fetch_idx][1];
      pcsrc      <= pcsrc_d;
      mispredict <= mis_d;
      flush      <= mis_d;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (train && br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if (mis_d && mp_count != 16'hFFFF) mp_count <= mp_count + 16'd1;
    end
  end
`endif

endmodule
